// File: rtl/sw_led_mmio.sv
// Memory-mapped LED/switch peripheral: LED and CTRL registers, debounced switch
// register with change flag (clear-on-read) and a level interrupt.
module sw_led_mmio #(
  parameter logic [15:0] BASE      = 16'hC000,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic        re,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        rd_vld,
  input  logic [9:0]  SW,
  output logic [9:0]  LEDR,
  output logic        sw_irq
);

  localparam logic [7:0] DB_MAX = 8'(DB_CYCLES);

  logic [9:0]  led_q, led_d;
  logic [9:0]  sw_s1_q, sw_s2_q;
  logic [9:0]  cand_q, cand_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [9:0]  sw_reg_q, sw_reg_d;
  logic        changed_q, changed_d;
  logic        irq_en_q, irq_en_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rd_vld_q;

  logic [15:0] off;
  logic        in_win;
  logic [15:0] rd_mux;
  logic        commit;
  logic        rd_status;

  // Window decode by offset so a BASE that is not 4-aligned still works.
  assign off       = addr - BASE;
  assign in_win    = (off[15:2] == 14'd0);
  assign rd_status = re && in_win && (off[1:0] == 2'd2);

  always_comb begin
    rd_mux = '0;
    if (in_win) begin
      case (off[1:0])
        2'd0:    rd_mux = {6'd0, led_q};
        2'd1:    rd_mux = {6'd0, sw_reg_q};
        2'd2:    rd_mux = {15'd0, changed_q};
        default: rd_mux = {15'd0, irq_en_q};
      endcase
    end
  end

  // Commit fires on the edge where the counter reaches DB_MAX, so it is
  // evaluated against the next-state count.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    sw_reg_d = sw_reg_q;
    commit   = 1'b0;
    if (sw_s2_q != cand_q) begin
      cand_d = sw_s2_q;
      cnt_d  = '0;
    end else begin
      if (cnt_q != DB_MAX) cnt_d = cnt_q + 8'd1;
      if ((cnt_d == DB_MAX) && (cand_q != sw_reg_q)) begin
        commit   = 1'b1;
        sw_reg_d = cand_q;
      end
    end
  end

  always_comb begin
    led_d     = led_q;
    irq_en_d  = irq_en_q;
    rdata_d   = rdata_q;
    changed_d = commit | (changed_q & ~rd_status);
    if (we && in_win && (off[1:0] == 2'd0)) led_d    = wdata[9:0];
    if (we && in_win && (off[1:0] == 2'd3)) irq_en_d = wdata[0];
    if (re) rdata_d = rd_mux;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q     <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      cand_q    <= '0;
      cnt_q     <= '0;
      sw_reg_q  <= '0;
      changed_q <= 1'b0;
      irq_en_q  <= 1'b0;
      rdata_q   <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      led_q     <= led_d;
      sw_s1_q   <= SW;
      sw_s2_q   <= sw_s1_q;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      sw_reg_q  <= sw_reg_d;
      changed_q <= changed_d;
      irq_en_q  <= irq_en_d;
      rdata_q   <= rdata_d;
      rd_vld_q  <= re;
    end
  end

  assign LEDR   = led_q;
  assign rdata  = rdata_q;
  assign rd_vld = rd_vld_q;
  assign sw_irq = changed_q & irq_en_q;

endmodule

// File: tb/tb_sw_led_mmio.sv
// Scoreboard bench for sw_led_mmio: reads push expected data, a negedge
// monitor pops on rd_vld; direct checks cover LEDR, sw_irq and reset.
module tb_sw_led_mmio;

  localparam logic [15:0] BASE = 16'hC000;

  logic        clk;
  logic        rst;
  logic [15:0] addr;
  logic        we;
  logic        re;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        rd_vld;
  logic [9:0]  SW;
  logic [9:0]  LEDR;
  logic        sw_irq;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [15:0] sb_q[$];
  logic [15:0] last_rdata = '0;

  sw_led_mmio #(.BASE(BASE), .DB_CYCLES(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .we    (we),
    .re    (re),
    .wdata (wdata),
    .rdata (rdata),
    .rd_vld(rd_vld),
    .SW    (SW),
    .LEDR  (LEDR),
    .sw_irq(sw_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected read data on every rd_vld, checks rdata holds otherwise.
  always @(negedge clk) begin
    if (rst) begin
      last_rdata = '0;
    end else if (rd_vld) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_vld: got rdata %h expected no read", rdata);
      end else begin
        chk("rdata", rdata, sb_q.pop_front());
      end
      last_rdata = rdata;
    end else begin
      chk("rdata_hold", rdata, last_rdata);
    end
  end

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, input logic [15:0] e);
    addr = a; re = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    re = 1'b0;
  endtask

  task automatic bus_rw(input logic [15:0] a, input logic [15:0] d, input logic [15:0] e);
    addr = a; wdata = d; we = 1'b1; re = 1'b1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    we = 1'b0; re = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr = '0; we = 1'b0; re = 1'b0; wdata = '0; SW = '0;
    idle(2);
    chk("reset_ledr", {6'd0, LEDR}, 16'h0000);
    chk("reset_irq", {15'd0, sw_irq}, 16'h0000);
    chk("reset_rd_vld", {15'd0, rd_vld}, 16'h0000);
    chk("reset_rdata", rdata, 16'h0000);
    rst = 1'b0;
    idle(2);

    // Glitch of DB_CYCLES clocks must not commit
    SW = 10'h3FF;
    idle(4);
    SW = 10'h000;
    idle(8);
    bus_rd(BASE + 16'd1, 16'h0000);
    bus_rd(BASE + 16'd2, 16'h0000);

    // Debounce latency: commit at N+6
    SW = 10'h155;
    idle(6);
    bus_rd(BASE + 16'd1, 16'h0000);
    bus_rd(BASE + 16'd1, 16'h0155);
    bus_rd(BASE + 16'd2, 16'h0001);
    bus_rd(BASE + 16'd2, 16'h0000);

    // Interrupt path
    bus_wr(BASE + 16'd3, 16'h0001);
    chk("irq_idle", {15'd0, sw_irq}, 16'h0000);
    SW = 10'h0AA;
    idle(6);
    chk("irq_before_commit", {15'd0, sw_irq}, 16'h0000);
    idle(1);
    chk("irq_after_commit", {15'd0, sw_irq}, 16'h0001);
    bus_rd(BASE + 16'd3, 16'h0001);
    chk("irq_held", {15'd0, sw_irq}, 16'h0001);
    bus_rd(BASE + 16'd2, 16'h0001);
    chk("irq_cleared", {15'd0, sw_irq}, 16'h0000);
    bus_rd(BASE + 16'd1, 16'h00AA);
    bus_wr(BASE + 16'd3, 16'h0000);

    // STATUS read on the commit edge leaves changed set
    SW = 10'h111;
    idle(6);
    bus_rd(BASE + 16'd2, 16'h0000);
    bus_rd(BASE + 16'd2, 16'h0001);
    bus_rd(BASE + 16'd2, 16'h0000);
    bus_rd(BASE + 16'd1, 16'h0111);

    // LED register, read-during-write, unused bits
    bus_wr(BASE, 16'h02A5);
    chk("ledr_2a5", {6'd0, LEDR}, 16'h02A5);
    bus_rd(BASE, 16'h02A5);
    bus_rw(BASE, 16'h0123, 16'h02A5);
    chk("ledr_123", {6'd0, LEDR}, 16'h0123);
    bus_wr(BASE, 16'hFFFF);
    bus_rd(BASE, 16'h03FF);

    // Out-of-window and read-only accesses
    bus_rd(BASE + 16'd4, 16'h0000);
    bus_rd(BASE - 16'd1, 16'h0000);
    bus_wr(BASE + 16'd1, 16'h03FF);
    bus_wr(BASE + 16'd2, 16'h0001);
    bus_wr(BASE + 16'd4, 16'h0000);
    bus_rd(BASE + 16'd1, 16'h0111);
    bus_rd(BASE + 16'd2, 16'h0000);
    bus_rd(BASE, 16'h03FF);
    chk("ledr_3ff", {6'd0, LEDR}, 16'h03FF);

    // Reset while a read result is being presented and another is in flight
    addr = BASE; re = 1'b1;
    @(posedge clk); #1;
    chk("rd_vld_pre_rst", {15'd0, rd_vld}, 16'h0001);
    rst = 1'b1;
    #1;
    chk("rst_ledr", {6'd0, LEDR}, 16'h0000);
    chk("rst_rd_vld", {15'd0, rd_vld}, 16'h0000);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_irq", {15'd0, sw_irq}, 16'h0000);
    idle(2);
    re = 1'b0;
    rst = 1'b0;
    idle(8);
    chk("post_rst_irq", {15'd0, sw_irq}, 16'h0000);
    bus_rd(BASE + 16'd1, 16'h0111);
    bus_rd(BASE + 16'd2, 16'h0001);
    bus_rd(BASE, 16'h0000);
    bus_rd(BASE + 16'd3, 16'h0000);

    idle(3);
    chk("sb_empty", 16'(sb_q.size()), 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
